vx_perf_event_ctrs: RTL and testbench

VX_PERF_EVENT_CTRS -- requirements
Module: VX_perf_event_ctrs

---
 rtl/vx_perf_pkg.sv | 33 +++
 rtl/vx_perf_ctr_cell.sv | 40 ++++
 rtl/vx_perf_event_ctrs.sv | 109 ++++++++++
 tb/tb_vx_perf_event_ctrs.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_perf_pkg.sv
// rtl/vx_perf_pkg.sv - shared performance-event indices, counter width and helpers
package vx_perf_pkg;

  localparam int PERF_CTR_BITS = 44;

  typedef enum logic [3:0] {
    PERF_LOADS,
    PERF_STORES,
    PERF_BRANCHES,
    PERF_ACTIVE_THREADS,
    PERF_IBF_STALLS,
    PERF_SCB_STALLS,
    PERF_LSU_STALLS,
    PERF_CSR_STALLS,
    PERF_ALU_STALLS,
    PERF_GPU_STALLS
`ifdef EXT_F_ENABLE
    , PERF_FPU_STALLS
`endif
  } perf_event_e;

`ifdef EXT_F_ENABLE
  localparam int NUM_PERF_EVENTS = 11;
`else
  localparam int NUM_PERF_EVENTS = 10;
`endif

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_perf_ctr_cell.sv
// rtl/vx_perf_ctr_cell.sv - one event counter with sticky overflow flag
module vx_perf_ctr_cell
  import vx_perf_pkg::*;
#(
  parameter int CTR_W    = PERF_CTR_BITS,
  parameter int INC_W    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [INC_W-1:0] inc,
  output logic [CTR_W-1:0] count,
  output logic             ovf
);

  logic [CTR_W:0] sum;

  // The extra top bit is the carry that marks an overflowing add.
  assign sum = {1'b0, count} + (CTR_W + 1)'(inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (enable) begin
      if (sum[CTR_W]) begin
        count <= (SATURATE != 0) ? '1 : sum[CTR_W-1:0];
        ovf   <= 1'b1;
      end else begin
        count <= sum[CTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vx_perf_event_ctrs.sv
// rtl/vx_perf_event_ctrs.sv - bank of event counters with a one-deep read-response channel
// Optional shadow snapshot registers are built when PERF_SNAPSHOT_EN is defined.
module vx_perf_event_ctrs
  import vx_perf_pkg::*;
#(
  parameter int NUM_EVENTS = 10,
  parameter int CTR_W      = PERF_CTR_BITS,
  parameter int INC_W      = 4,
  parameter int SATURATE   = 0,
  localparam int IDX_W     = idx_width(NUM_EVENTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clear,
`ifdef PERF_SNAPSHOT_EN
  input  logic                        snap,
`endif
  input  logic [NUM_EVENTS*INC_W-1:0] evt_inc,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [IDX_W-1:0]            req_idx,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [CTR_W-1:0]            rsp_data,
  output logic                        rsp_ovf,
  output logic                        rsp_err
);

  logic [NUM_EVENTS-1:0][CTR_W-1:0] live_cnt;
  logic [NUM_EVENTS-1:0]            live_ovf;
  logic [NUM_EVENTS-1:0][CTR_W-1:0] src_cnt;
  logic [NUM_EVENTS-1:0]            src_ovf;
  logic [CTR_W-1:0]                 rd_data;
  logic                             rd_ovf;
  logic                             rd_err;
  logic                             req_fire;

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cell
    vx_perf_ctr_cell #(
      .CTR_W    (CTR_W),
      .INC_W    (INC_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .inc    (evt_inc[i*INC_W +: INC_W]),
      .count  (live_cnt[i]),
      .ovf    (live_ovf[i])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic [NUM_EVENTS-1:0][CTR_W-1:0] shadow_cnt;
  logic [NUM_EVENTS-1:0]            shadow_ovf;

  // Captures the registered (pre-clear, pre-increment) values of this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_cnt <= '0;
      shadow_ovf <= '0;
    end else if (snap) begin
      shadow_cnt <= live_cnt;
      shadow_ovf <= live_ovf;
    end
  end

  assign src_cnt = shadow_cnt;
  assign src_ovf = shadow_ovf;
`else
  assign src_cnt = live_cnt;
  assign src_ovf = live_ovf;
`endif

  always_comb begin
    rd_data = '0;
    rd_ovf  = 1'b0;
    rd_err  = 1'b1;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (req_idx == IDX_W'(i)) begin
        rd_data = src_cnt[i];
        rd_ovf  = src_ovf[i];
        rd_err  = 1'b0;
      end
    end
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign req_fire  = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (req_fire) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_data;
      rsp_ovf   <= rd_ovf;
      rsp_err   <= rd_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_perf_event_ctrs.sv
// tb/tb_vx_perf_event_ctrs.sv - scoreboard bench for wrap and saturate counter banks
module tb_vx_perf_event_ctrs;

  localparam int NE   = 10;
  localparam int CW   = 8;
  localparam int IW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic             req_valid = 1'b0;
  logic             rsp_ready = 1'b1;
  logic [NE*IW-1:0] evt_inc = '0;
  logic [3:0]       req_idx = '0;
`ifdef PERF_SNAPSHOT_EN
  logic             snap = 1'b0;
`endif

  logic          rq[2];
  logic          rv[2];
  logic          ro[2];
  logic          re[2];
  logic [CW-1:0] rd[2];

  always #5 clk = ~clk;

  vx_perf_event_ctrs #(.NUM_EVENTS(NE), .CTR_W(CW), .INC_W(IW), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap),
`endif
    .evt_inc(evt_inc), .req_valid(req_valid), .req_ready(rq[0]), .req_idx(req_idx),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_data(rd[0]), .rsp_ovf(ro[0]), .rsp_err(re[0])
  );

  vx_perf_event_ctrs #(.NUM_EVENTS(NE), .CTR_W(CW), .INC_W(IW), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap),
`endif
    .evt_inc(evt_inc), .req_valid(req_valid), .req_ready(rq[1]), .req_idx(req_idx),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_data(rd[1]), .rsp_ovf(ro[1]), .rsp_err(re[1])
  );

  typedef struct {
    int data;
    bit ovf;
    bit err;
  } exp_t;

  exp_t sq[2][$];
  exp_t mon_e;
  int   m_cnt[2][NE];
  bit   m_ovf[2][NE];
  int   m_sh_cnt[2][NE];
  bit   m_sh_ovf[2][NE];
  bit   m_valid;
  int   m_sum;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pops[2];
  int   last_d[2];
  bit   last_o[2];
  bit   last_e[2];
  int   p0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_read(input int k, input int idx);
    exp_t e;
    e.data = 0;
    e.ovf  = 1'b0;
    e.err  = (idx >= NE);
    if (idx < NE) begin
`ifdef PERF_SNAPSHOT_EN
      e.data = m_sh_cnt[k][idx];
      e.ovf  = m_sh_ovf[k][idx];
`else
      e.data = m_cnt[k][idx];
      e.ovf  = m_ovf[k][idx];
`endif
    end
    return e;
  endfunction

  // Reference model: a read sees the state before this edge's update.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        sq[k].delete();
        for (int i = 0; i < NE; i++) begin
          m_cnt[k][i] = 0; m_ovf[k][i] = 1'b0;
          m_sh_cnt[k][i] = 0; m_sh_ovf[k][i] = 1'b0;
        end
      end
    end else begin
      if (req_valid && (!m_valid || rsp_ready)) begin
        for (int k = 0; k < 2; k++) sq[k].push_back(model_read(k, int'(req_idx)));
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
`ifdef PERF_SNAPSHOT_EN
      if (snap) begin
        m_sh_cnt = m_cnt;
        m_sh_ovf = m_ovf;
      end
`endif
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NE; i++) begin
          if (clear) begin
            m_cnt[k][i] = 0;
            m_ovf[k][i] = 1'b0;
          end else if (enable) begin
            m_sum = m_cnt[k][i] + int'(evt_inc[i*IW +: IW]);
            if (m_sum > MAXV) begin
              m_ovf[k][i] = 1'b1;
              m_cnt[k][i] = (k == 0) ? (m_sum % (MAXV + 1)) : MAXV;
            end else begin
              m_cnt[k][i] = m_sum;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), rq[k], !m_valid || rsp_ready);
        chk($sformatf("rsp_valid[%0d]", k), rv[k], m_valid);
        if (rv[k]) begin
          if (sq[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected[%0d]: got valid response data %0d, expected none", k, rd[k]);
          end else begin
            mon_e = sq[k][0];
            chk($sformatf("rsp_data[%0d]", k), rd[k], mon_e.data);
            chk($sformatf("rsp_ovf[%0d]", k), ro[k], mon_e.ovf);
            chk($sformatf("rsp_err[%0d]", k), re[k], mon_e.err);
            if (rsp_ready) begin
              void'(sq[k].pop_front());
              pops[k]++;
              last_d[k] = int'(rd[k]);
              last_o[k] = ro[k];
              last_e[k] = re[k];
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc(input int idx, input int v);
    evt_inc = '0;
    evt_inc[idx*IW +: IW] = v[IW-1:0];
  endtask

  task automatic read_one(input int idx);
`ifdef PERF_SNAPSHOT_EN
    snap = 1'b1;
    tick();
    snap = 1'b0;
`endif
    req_valid = 1'b1;
    req_idx   = idx[3:0];
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    pops = '{0, 0};
    repeat (3) tick();
    chk("reset_rsp_valid", rv[0], 0);
    chk("reset_rsp_data", rd[1], 0);
    reset = 1'b1;
    tick();

    set_inc(2, 3);
    enable = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    evt_inc = '0;
    read_one(2);
    chk("basic_data", last_d[0], 15);
    chk("basic_ovf", last_o[0], 0);
    chk("basic_data_sat", last_d[1], 15);

    set_inc(0, 10);
    enable = 1'b1;
    repeat (25) tick();
    set_inc(0, 9);
    tick();
    enable = 1'b0;
    evt_inc = '0;
    read_one(0);
    chk("wrap_data", last_d[0], 3);
    chk("wrap_ovf", last_o[0], 1);
    chk("sat_data", last_d[1], 255);
    chk("sat_ovf", last_o[1], 1);

    set_inc(0, 4);
    enable = 1'b1;
    clear = 1'b1;
    req_valid = 1'b1;
    req_idx = 4'd0;
    rsp_ready = 1'b1;
    tick();
    clear = 1'b0;
    enable = 1'b0;
    evt_inc = '0;
    req_valid = 1'b0;
    tick();
    chk("clear_read_preclear", last_d[0], 3);
    chk("clear_read_preclear_ovf", last_o[0], 1);
    read_one(0);
    chk("after_clear_wrap", last_d[0], 0);
    chk("after_clear_sat", last_d[1], 0);
    chk("after_clear_ovf", last_o[1], 0);

    set_inc(1, 5);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    evt_inc = '0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_idx = 4'd1;
    tick();
    req_idx = 4'd3;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("stall_req_ready", rq[0], 0);
      chk("stall_rsp_valid", rv[0], 1);
    end
    p0 = pops[0];
    rsp_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      req_idx = 4'(j);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_responses", pops[0] - p0, 5);

    read_one(NE);
    chk("bad_idx_err", last_e[0], 1);
    chk("bad_idx_data", last_d[0], 0);

`ifdef PERF_SNAPSHOT_EN
    set_inc(5, 1);
    enable = 1'b1;
    repeat (7) tick();
    enable = 1'b0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    evt_inc = '0;
    req_valid = 1'b1;
    req_idx = 4'd5;
    tick();
    req_valid = 1'b0;
    tick();
    chk("snapshot_value", last_d[0], 7);
`endif

    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      evt_inc   = 40'({$urandom(), $urandom()});
      req_valid = $urandom_range(0, 1) != 0;
      req_idx   = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef PERF_SNAPSHOT_EN
      snap      = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    evt_inc = '0;
`ifdef PERF_SNAPSHOT_EN
    snap = 1'b0;
`endif
    tick();
    tick();
    chk("queue_drained", sq[0].size(), 0);

    set_inc(3, 2);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    evt_inc = '0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_idx = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("pre_reset_valid", rv[0], 1);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_valid_wrap", rv[0], 0);
    chk("reset_mid_valid_sat", rv[1], 0);
    chk("reset_mid_req_ready", rq[0], 1);
    tick();
    reset = 1'b1;
    chk("post_reset_req_ready", rq[0], 1);
    read_one(3);
    chk("post_reset_count", last_d[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
